// File: rtl/ebr_ramdp_par.sv
// Single-clock pseudo-dual-port EBR RAM with internal parity, post-reset init
// sequencer, write-first bypass, optional output register and parity-error counter.
module ebr_ramdp_par #(
  parameter int unsigned           DATA_WIDTH = 4,
  parameter int unsigned           ADDR_WIDTH = 4,
  parameter int unsigned           DEPTH      = 16,
  parameter int unsigned           OUT_REG    = 0,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '1
) (
  input  logic                  Clock,
  input  logic                  ResetN,
  input  logic                  WrEn,
  input  logic [ADDR_WIDTH-1:0] WrAddress,
  input  logic [DATA_WIDTH-1:0] Data,
  input  logic                  ParityInv,
  input  logic                  RdEn,
  input  logic [ADDR_WIDTH-1:0] RdAddress,
  output logic [DATA_WIDTH-1:0] Q,
  output logic                  QValid,
  output logic                  ParityErr,
  output logic [7:0]            ErrCount,
  output logic                  Busy
);

  localparam int unsigned WORD_WIDTH = DATA_WIDTH + 1;
  localparam int unsigned IDX_WIDTH  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [WORD_WIDTH-1:0] INIT_WORD = {^INIT_VALUE, INIT_VALUE};
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

  typedef enum logic {ST_INIT, ST_READY} state_t;

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   init_addr_q, init_addr_d;
  logic                    busy_q;

  logic [WORD_WIDTH-1:0]   mem [DEPTH];

  logic                    ready;
  logic                    wr_in_range, rd_in_range;
  logic                    wr_accept, rd_accept, rd_hit;
  logic [WORD_WIDTH-1:0]   wr_word, rd_word;
  logic                    mem_we;
  logic [ADDR_WIDTH-1:0]   mem_addr;
  logic [WORD_WIDTH-1:0]   mem_wdata;

  logic                    s1_valid;
  logic [WORD_WIDTH-1:0]   s1_word;
  logic                    chk_valid;
  logic [WORD_WIDTH-1:0]   chk_word;
  logic                    chk_err;

  // Init sequencer: walk every word once, then serve the ports.
  always_comb begin
    state_d     = state_q;
    init_addr_d = init_addr_q;
    case (state_q)
      ST_INIT: begin
        init_addr_d = init_addr_q + ADDR_WIDTH'(1);
        if (init_addr_q == LAST_ADDR) begin
          state_d     = ST_READY;
          init_addr_d = '0;
        end
      end
      ST_READY: ;
      default: begin
        state_d     = ST_INIT;
        init_addr_d = '0;
      end
    endcase
  end

  always_ff @(posedge Clock) begin
    if (!ResetN) begin
      state_q     <= ST_INIT;
      init_addr_q <= '0;
      busy_q      <= 1'b1;
    end else begin
      state_q     <= state_d;
      init_addr_q <= init_addr_d;
      busy_q      <= (state_d == ST_INIT);
    end
  end

  assign Busy = busy_q;

  // Port qualification and the shared write port (sequencer has priority).
  always_comb begin
    ready       = (state_q == ST_READY);
    wr_in_range = (32'(WrAddress) < DEPTH);
    rd_in_range = (32'(RdAddress) < DEPTH);
    wr_accept   = ready && WrEn && wr_in_range;
    rd_accept   = ready && RdEn;
    wr_word     = {(^Data) ^ ParityInv, Data};
    mem_we      = wr_accept;
    mem_addr    = WrAddress;
    mem_wdata   = wr_word;
    if (state_q == ST_INIT) begin
      mem_we    = 1'b1;
      mem_addr  = init_addr_q;
      mem_wdata = INIT_WORD;
    end
  end

  always_ff @(posedge Clock) begin
    if (ResetN && mem_we) begin
      mem[IDX_WIDTH'(mem_addr)] <= mem_wdata;
    end
  end

  // Write-first: a same-address write in this cycle overrides the stored word.
  always_comb begin
    rd_hit  = wr_accept && (RdAddress == WrAddress);
    rd_word = '0;
    if (rd_hit) begin
      rd_word = wr_word;
    end else if (rd_in_range) begin
      rd_word = mem[IDX_WIDTH'(RdAddress)];
    end
  end

  always_ff @(posedge Clock) begin
    if (!ResetN) begin
      s1_valid <= 1'b0;
      s1_word  <= '0;
    end else begin
      s1_valid <= rd_accept;
      if (rd_accept) begin
        s1_word <= rd_word;
      end
    end
  end

  generate
    if (OUT_REG != 0) begin : g_out_reg
      logic                  s2_valid;
      logic [WORD_WIDTH-1:0] s2_word;

      always_ff @(posedge Clock) begin
        if (!ResetN) begin
          s2_valid <= 1'b0;
          s2_word  <= '0;
        end else begin
          s2_valid <= s1_valid;
          if (s1_valid) begin
            s2_word <= s1_word;
          end
        end
      end

      assign chk_valid = s2_valid;
      assign chk_word  = s2_word;
    end else begin : g_no_out_reg
      assign chk_valid = s1_valid;
      assign chk_word  = s1_word;
    end
  endgenerate

  assign chk_err = chk_word[DATA_WIDTH] ^ (^chk_word[DATA_WIDTH-1:0]);

  // Output register with parity check and saturating error counter.
  always_ff @(posedge Clock) begin
    if (!ResetN) begin
      Q         <= '0;
      QValid    <= 1'b0;
      ParityErr <= 1'b0;
      ErrCount  <= '0;
    end else begin
      QValid    <= chk_valid;
      ParityErr <= chk_valid && chk_err;
      if (chk_valid) begin
        Q <= chk_word[DATA_WIDTH-1:0];
      end
      if (chk_valid && chk_err && (ErrCount != 8'hFF)) begin
        ErrCount <= ErrCount + 8'd1;
      end
    end
  end

endmodule
